bus_slave_ram: RTL and testbench

Word-addressed RAM responder that sits on one slave port of `bus_top`. It decodes its chip select plus the shared slave-side bus signals (`slave_as`, `slave_addr`, `slave_wr`, `slave_wr_data`) into a read or write of a local memory. It returns `rdy`/`out_data` after a configurable number of wait states. It is the responder end of the master→arbiter→decoder path and is instantiated once per populated slave slot (`slave_0`..`slave_7`).

---
 rtl/bus_slave_ram_pkg.sv | 28 ++
 rtl/bus_slave_ram_if.sv | 34 +++
 rtl/bus_slave_ram_mem.sv | 31 +++
 rtl/bus_slave_ram.sv | 145 ++++++++++++++
 tb/tb_bus_slave_ram.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/bus_slave_ram_pkg.sv
// Shared definitions for the bus_slave_ram responder: bus widths, the
// direction encoding, slot-select width, FSM state encoding and the
// address range helper.
package bus_slave_ram_pkg;

  localparam int ADDR_WIDTH = 30;
  localparam int DATA_WIDTH = 32;
  localparam int SLOT_W     = 3;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  typedef enum logic [1:0] {
    SLV_IDLE = 2'd0,
    SLV_WAIT = 2'd1,
    SLV_RESP = 2'd2
  } slv_state_t;

  // The slot bits are stripped before this is called; any bit at or above
  // depth_log2 in the remaining address means the word is not backed by RAM.
  function automatic logic addr_in_range(
    input logic [ADDR_WIDTH-SLOT_W-1:0] local_addr,
    input int unsigned                  depth_log2
  );
    return (local_addr >> depth_log2) == '0;
  endfunction

endpackage

// File: rtl/bus_slave_ram_if.sv
// Slave-slot bus bundle between the decoder side (master) and one
// bus_slave_ram responder (slave). The err line exists only when
// BUS_SLAVE_RAM_ERR_EN is defined.
interface bus_slave_ram_if;
  import bus_slave_ram_pkg::*;

  logic                  cs;
  logic                  as;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  wr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rdy;
  logic [DATA_WIDTH-1:0] out_data;
`ifdef BUS_SLAVE_RAM_ERR_EN
  logic                  err;
`endif

  modport master (
    output cs, as, addr, wr, wr_data,
`ifdef BUS_SLAVE_RAM_ERR_EN
    input  err,
`endif
    input  rdy, out_data
  );

  modport slave (
    input  cs, as, addr, wr, wr_data,
`ifdef BUS_SLAVE_RAM_ERR_EN
    output err,
`endif
    output rdy, out_data
  );

endinterface

// File: rtl/bus_slave_ram_mem.sv
// Single-port synchronous RAM with read-first registered output. Contents
// are never reset so the array maps onto block RAM.
module bus_slave_ram_mem
  import bus_slave_ram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem_array [2**DEPTH_LOG2];
  logic [DATA_WIDTH-1:0] dout_reg;

  // Enabled access: optional write, and registered read of the same word.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_array[idx] <= din;
      end
      dout_reg <= mem_array[idx];
    end
  end

  assign dout = dout_reg;

endmodule

// File: rtl/bus_slave_ram.sv
// bus_slave_ram: word-addressed RAM responder on one bus slave slot.
// Accepts a request in IDLE, waits WAIT_CYCLES (0..15) with the request
// held, executes the access on the edge entering RESP and pulses rdy for
// one cycle. Define BUS_SLAVE_RAM_ERR_EN to add the err output, which
// flags out-of-range accesses alongside rdy.
module bus_slave_ram
  import bus_slave_ram_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int DEPTH_LOG2  = 10
) (
  input  logic          clk,
  input  logic          rst_,
  bus_slave_ram_if.slave bus
);

  localparam int         LOCAL_W   = ADDR_WIDTH - SLOT_W;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  slv_state_t            state_reg, state_next;
  logic [3:0]            cnt_reg, cnt_next;
  logic [LOCAL_W-1:0]    addr_lat_reg;
  logic                  wr_lat_reg;
  logic [DATA_WIDTH-1:0] wdata_lat_reg;
  logic                  rdy_reg;
  logic                  rd_ok_reg;
  logic                  err_reg;

  logic                  req;
  logic                  enter_resp;
  logic [LOCAL_W-1:0]    acc_addr;
  logic                  acc_wr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  acc_in_range;
  logic                  mem_en;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic                  slot_bits_unused;

  assign req = bus.cs & bus.as;

  // The slot-select bits were already consumed by the upstream decoder.
  assign slot_bits_unused = ^bus.addr[ADDR_WIDTH-1:LOCAL_W];

  // Next-state and wait-counter logic; enter_resp marks the access edge.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    enter_resp = 1'b0;
    case (state_reg)
      SLV_IDLE: begin
        if (req) begin
          cnt_next = WAIT_LOAD;
          if (WAIT_LOAD == 4'd0) begin
            state_next = SLV_RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = SLV_WAIT;
          end
        end
      end
      SLV_WAIT: begin
        if (!req) begin
          state_next = SLV_IDLE;
          cnt_next   = 4'd0;
        end else if (cnt_reg == 4'd1) begin
          state_next = SLV_RESP;
          enter_resp = 1'b1;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      SLV_RESP: begin
        state_next = SLV_IDLE;
      end
      default: begin
        state_next = SLV_IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // With zero wait states the access happens on the acceptance edge, so the
  // live bus fields feed the RAM; otherwise the latched copy does.
  assign acc_addr     = (state_reg == SLV_IDLE) ? bus.addr[LOCAL_W-1:0] : addr_lat_reg;
  assign acc_wr       = (state_reg == SLV_IDLE) ? bus.wr : wr_lat_reg;
  assign acc_wdata    = (state_reg == SLV_IDLE) ? bus.wr_data : wdata_lat_reg;
  assign acc_in_range = addr_in_range(acc_addr, DEPTH_LOG2);

  // Reset on the access edge must suppress the write as well.
  assign mem_en = enter_resp & ~rst_;
  assign mem_we = mem_en & (acc_wr == WRITE) & acc_in_range;

  // FSM state, wait counter and request latch.
  always_ff @(posedge clk) begin
    if (rst_) begin
      state_reg     <= SLV_IDLE;
      cnt_reg       <= 4'd0;
      addr_lat_reg  <= '0;
      wr_lat_reg    <= READ;
      wdata_lat_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == SLV_IDLE && req) begin
        addr_lat_reg  <= bus.addr[LOCAL_W-1:0];
        wr_lat_reg    <= bus.wr;
        wdata_lat_reg <= bus.wr_data;
      end
    end
  end

  // Response strobes: rdy for every completed access, rd_ok only for an
  // in-range read so out_data stays zero otherwise.
  always_ff @(posedge clk) begin
    if (rst_) begin
      rdy_reg   <= 1'b0;
      rd_ok_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      rdy_reg   <= enter_resp;
      rd_ok_reg <= enter_resp & (acc_wr == READ) & acc_in_range;
      err_reg   <= enter_resp & ~acc_in_range;
    end
  end

  bus_slave_ram_mem #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk  (clk),
    .en   (mem_en),
    .we   (mem_we),
    .idx  (acc_addr[DEPTH_LOG2-1:0]),
    .din  (acc_wdata),
    .dout (mem_dout)
  );

  assign bus.rdy      = rdy_reg;
  assign bus.out_data = rd_ok_reg ? mem_dout : '0;
`ifdef BUS_SLAVE_RAM_ERR_EN
  assign bus.err      = err_reg;
`endif

endmodule

// File: tb/tb_bus_slave_ram.sv
// Testbench for bus_slave_ram: two responders (WAIT_CYCLES 0 and 3) share
// as/addr/wr/wr_data with separate chip selects, like two slots on one bus.
// Table-driven transactions plus hand-written abort, held-request and
// reset-during-wait sequences. Honours BUS_SLAVE_RAM_ERR_EN for err checks.
module tb_bus_slave_ram;
  import bus_slave_ram_pkg::*;

  logic clk = 1'b0;
  logic rst_ = 1'b1;
  always #5 clk = ~clk;

  bus_slave_ram_if if0 ();
  bus_slave_ram_if if3 ();

  bus_slave_ram #(.WAIT_CYCLES(0), .DEPTH_LOG2(10)) dut0 (
    .clk (clk), .rst_(rst_), .bus(if0.slave)
  );
  bus_slave_ram #(.WAIT_CYCLES(3), .DEPTH_LOG2(10)) dut3 (
    .clk (clk), .rst_(rst_), .bus(if3.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string                 name;
    int                    sel;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] exp_data;
    bit                    exp_oor;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic get_rdy(input int sel);
    return (sel == 0) ? if0.rdy : if3.rdy;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] get_data(input int sel);
    return (sel == 0) ? if0.out_data : if3.out_data;
  endfunction

`ifdef BUS_SLAVE_RAM_ERR_EN
  function automatic logic get_err(input int sel);
    return (sel == 0) ? if0.err : if3.err;
  endfunction
`endif

  task automatic drive(input int sel, input logic c, input logic a, input logic w,
                       input logic [ADDR_WIDTH-1:0] ad, input logic [DATA_WIDTH-1:0] d);
    if0.cs = (sel == 0) && c;
    if3.cs = (sel == 3) && c;
    if0.as = a;       if3.as = a;
    if0.addr = ad;    if3.addr = ad;
    if0.wr = w;       if3.wr = w;
    if0.wr_data = d;  if3.wr_data = d;
  endtask

  task automatic idle();
    drive(0, 1'b0, 1'b0, READ, '0, '0);
  endtask

  // One complete transaction: present, wait for rdy (bounded), check latency,
  // data, quiet out_data before rdy, and rdy low the cycle after.
  task automatic txn(input string name, input int sel, input logic w,
                     input logic [ADDR_WIDTH-1:0] ad, input logic [DATA_WIDTH-1:0] d,
                     input logic [DATA_WIDTH-1:0] exp_d, input bit exp_oor);
    int wc;
    int lat;
    int zero_bad;
    logic [DATA_WIDTH-1:0] data_at;
    logic err_at;
    wc = (sel == 0) ? 0 : 3;
    lat = -1;
    zero_bad = 0;
    data_at = '0;
    err_at = 1'b0;
    drive(sel, 1'b1, 1'b1, w, ad, d);
    for (int k = 0; k <= wc + 3; k++) begin
      @(posedge clk); #1;
      if (get_rdy(sel)) begin
        lat = k;
        data_at = get_data(sel);
`ifdef BUS_SLAVE_RAM_ERR_EN
        err_at = get_err(sel);
`endif
        break;
      end
      if (get_data(sel) !== '0) zero_bad++;
    end
    idle();
    check({name, "_latency"}, 32'(lat), 32'(wc));
    check({name, "_data"}, data_at, exp_d);
    check({name, "_quiet"}, 32'(zero_bad), 32'd0);
`ifdef BUS_SLAVE_RAM_ERR_EN
    check({name, "_err"}, 32'(err_at), 32'(exp_oor));
`else
    if (exp_oor) err_at = 1'b0;
`endif
    @(posedge clk); #1;
    check({name, "_rdy_after"}, {31'd0, get_rdy(sel)}, 32'd0);
    $display("txn %s sel=%0d wr=%0d addr=%h wdata=%h out=%h lat=%0d err=%0d",
             name, sel, w, ad, d, data_at, lat, err_at);
  endtask

  // Request held continuously: rdy must recur every WAIT+2 cycles.
  task automatic held(input int sel, input logic [ADDR_WIDTH-1:0] ad,
                      input logic [DATA_WIDTH-1:0] exp_d);
    int wc;
    int period;
    int n;
    int pulses;
    logic exp_rdy;
    wc = (sel == 0) ? 0 : 3;
    period = wc + 2;
    n = 4 * period - 1;
    pulses = 0;
    drive(sel, 1'b1, 1'b1, READ, ad, '0);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      exp_rdy = ((k % period) == wc);
      check($sformatf("held%0d_rdy_k%0d", sel, k), {31'd0, get_rdy(sel)}, {31'd0, exp_rdy});
      check($sformatf("held%0d_data_k%0d", sel, k), get_data(sel), exp_rdy ? exp_d : '0);
      if (get_rdy(sel)) pulses++;
    end
    idle();
    @(posedge clk); #1;
    $display("txn held sel=%0d addr=%h cycles=%0d pulses=%0d", sel, ad, n, pulses);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;

    vecs[0]  = '{"w0_005",   0, WRITE, 30'h005,        32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{"r0_005",   0, READ,  30'h005,        32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{"w3_020",   3, WRITE, 30'h020,        32'h12345678, 32'h0,        1'b0};
    vecs[3]  = '{"r3_020",   3, READ,  30'h020,        32'h0,        32'h12345678, 1'b0};
    vecs[4]  = '{"w3_010",   3, WRITE, 30'h010,        32'h11112222, 32'h0,        1'b0};
    vecs[5]  = '{"w0_000",   0, WRITE, 30'h000,        32'hCAFEF00D, 32'h0,        1'b0};
    vecs[6]  = '{"w0_400",   0, WRITE, 30'h400,        32'h0BADBAD0, 32'h0,        1'b1};
    vecs[7]  = '{"r0_400",   0, READ,  30'h400,        32'h0,        32'h0,        1'b1};
    vecs[8]  = '{"r0_000",   0, READ,  30'h000,        32'h0,        32'hCAFEF00D, 1'b0};
    vecs[9]  = '{"r0_slot5", 0, READ,  30'h2800_0005,  32'h0,        32'hDEADBEEF, 1'b0};
    vecs[10] = '{"w0_3ff",   0, WRITE, 30'h3FF,        32'h55AA55AA, 32'h0,        1'b0};
    vecs[11] = '{"r0_3ff",   0, READ,  30'h3FF,        32'h0,        32'h55AA55AA, 1'b0};
    vecs[12] = '{"r3_7ff",   3, READ,  30'h7FF,        32'h0,        32'h0,        1'b1};

    // Reset state
    rst_ = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdy0", {31'd0, if0.rdy}, 32'd0);
    check("reset_rdy3", {31'd0, if3.rdy}, 32'd0);
    check("reset_data0", if0.out_data, 32'd0);
    check("reset_data3", if3.out_data, 32'd0);
`ifdef BUS_SLAVE_RAM_ERR_EN
    check("reset_err0", {31'd0, if0.err}, 32'd0);
    check("reset_err3", {31'd0, if3.err}, 32'd0);
`endif
    rst_ = 1'b0;
    @(posedge clk); #1;

    // Table-driven transactions
    for (int i = 0; i < 13; i++) begin
      txn(vecs[i].name, vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
          vecs[i].exp_data, vecs[i].exp_oor);
    end

    // Abort: write dropped after two cycles in WAIT, no rdy, word unchanged
    drive(3, 1'b1, 1'b1, WRITE, 30'h010, 32'hAAAA0000);
    @(posedge clk); #1;
    check("abort_rdy_e0", {31'd0, if3.rdy}, 32'd0);
    @(posedge clk); #1;
    check("abort_rdy_e1", {31'd0, if3.rdy}, 32'd0);
    if0.as = 1'b0;
    if3.as = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (if3.rdy) cnt++;
    end
    check("abort_no_rdy", 32'(cnt), 32'd0);
    idle();
    $display("txn abort sel=3 addr=010 wdata=aaaa0000 rdy_pulses=%0d", cnt);
    txn("abort_readback", 3, READ, 30'h010, 32'h0, 32'h11112222, 1'b0);

    // Held requests on both slots
    held(3, 30'h020, 32'h12345678);
    held(0, 30'h005, 32'hDEADBEEF);

    // Reset during WAIT of a write
    drive(3, 1'b1, 1'b1, WRITE, 30'h020, 32'hFFFF0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_ = 1'b1;
    @(posedge clk); #1;
    check("rstwait_rdy", {31'd0, if3.rdy}, 32'd0);
    check("rstwait_data", if3.out_data, 32'd0);
`ifdef BUS_SLAVE_RAM_ERR_EN
    check("rstwait_err", {31'd0, if3.err}, 32'd0);
`endif
    rst_ = 1'b0;
    idle();
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (if3.rdy) cnt++;
    end
    check("rstwait_no_rdy", 32'(cnt), 32'd0);
    $display("txn reset_in_wait sel=3 addr=020 wdata=ffff0000 rdy_pulses=%0d", cnt);
    txn("rstwait_readback", 3, READ, 30'h020, 32'h0, 32'h12345678, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
